dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller with a fixed wait-state count.
// Ports:
//   clk, rst      - clock and async active-high reset
//   req_*         - valid/ready request channel
//   rsp_*         - valid/ready response channel
//   dbg_idx/word  - side-effect-free combinational word peek
module dmem_ctrl #(
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err,
   input  logic [$clog2(DEPTH)-1:0] dbg_idx,
   output logic [31:0]              dbg_word
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];

   // In IDLE the access may happen on the accept edge itself, so the
   // live request is used; afterwards the latched copy governs.
   logic        cur_we;
   logic        cur_uns;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;

   assign cur_we    = (state_q == IDLE) ? req_we       : we_q;
   assign cur_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
   assign cur_size  = (state_q == IDLE) ? req_size     : size_q;
   assign cur_addr  = (state_q == IDLE) ? req_addr     : addr_q;
   assign cur_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;

   logic          fault;
   logic [AW-1:0] idx;
   logic [4:0]    sh;
   logic [31:0]   word_rd;
   logic [31:0]   byte_sh;
   logic [31:0]   half_sh;
   logic [31:0]   ld_val;
   logic [31:0]   base_m;
   logic [31:0]   st_m;
   logic [31:0]   st_word;
   logic          enter_resp;
   logic          mem_we;

   always_comb begin
      fault = 1'b0;
      if (cur_size == 2'b11)
         fault = 1'b1;
      if (cur_size == 2'b01 && cur_addr[0])
         fault = 1'b1;
      if (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
         fault = 1'b1;
      if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH))
         fault = 1'b1;
   end

   assign idx     = cur_addr[AW+1:2];
   assign sh      = {cur_addr[1:0], 3'b000};
   assign word_rd = mem_q[idx];
   assign byte_sh = word_rd >> sh;
   assign half_sh = word_rd >> {cur_addr[1], 4'b0000};

   always_comb begin
      ld_val = word_rd;
      base_m = 32'hFFFF_FFFF;
      unique case (cur_size)
         2'b00: begin
            base_m = 32'h0000_00FF;
            if (cur_uns)
               ld_val = {24'h0, byte_sh[7:0]};
            else
               ld_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
         end
         2'b01: begin
            base_m = 32'h0000_FFFF;
            if (cur_uns)
               ld_val = {16'h0, half_sh[15:0]};
            else
               ld_val = {{16{half_sh[15]}}, half_sh[15:0]};
         end
         default: begin
            base_m = 32'hFFFF_FFFF;
            ld_val = word_rd;
         end
      endcase
   end

   // Halves and words are aligned when not faulting, so the byte shift
   // places every size on its lanes.
   assign st_m    = base_m << sh;
   assign st_word = (word_rd & ~st_m) | ((cur_wdata << sh) & st_m);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      uns_d      = uns_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               uns_d   = req_unsigned;
               size_d  = req_size;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0 || fault) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         err_d   = fault;
         rdata_d = (fault || cur_we) ? 32'h0 : ld_val;
      end
   end

   // Reset may coincide with an edge; no write may slip through then.
   assign mem_we = enter_resp && cur_we && !fault && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[idx] <= st_word;
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_word  = mem_q[dbg_idx];

endmodule
